uart_rx_deser: RTL and testbench
================================

Name: uart_rx_deser

Overview:
- UART 8N1 receive deserializer. Converts the asynchronous RX pin into bytes on a valid/ready stream.
- Sits directly downstream of the board RX pin and upstream of byte consumers such as uart_mul's processing core.
- Single clock domain. Runs at the same ClockFrequency/DesiredBaudRate pair as the rest of the UART path.

Parameters:
- DesiredBaudRate, 9_600, line bit rate in baud.
- ClockFrequency, 12_000_000, clk_i frequency in Hz.
- Derived, not overridable: Divisor = ClockFrequency/DesiredBaudRate (integer truncation), HalfBit = Divisor/2, counter width = $clog2(Divisor). Elaboration error if Divisor < 4.

Ports:
- clk_i  input  1  system clock.
- rst_ni  input  1  reset; asynchronous assert, active-low.
- rx_i  input  1  raw serial line, idle high, asynchronous to clk_i.
- data_o  output  8  received byte, LSB first on the line.
- valid_o  output  1  data_o holds an unconsumed byte.
- ready_i  input  1  consumer accepts data_o this cycle.
- frame_err_o  output  1  one-cycle pulse: stop bit sampled low.
- overrun_o  output  1  one-cycle pulse: good byte dropped because the holding register was full.
- busy_o  output  1  high in any state other than IDLE.

Behaviour:
- Reset (async, rst_ni=0):
  - Synchronizer flops = 1.
  - State = IDLE; counter = 0; bit index = 0; shift register = 0.
  - data_o = 0x00; valid_o, frame_err_o, overrun_o, busy_o = 0.
  - Reset mid-frame abandons the frame with no pulses. After release, the block waits in IDLE for a falling edge.
- Synchronizer: two flops on rx_i produce rx_s. All decisions use rx_s (2-cycle latency from the pin).
- IDLE:
  - rx_s==0 -> START, counter=0.
- START:
  - Counter increments each cycle.
  - At counter==HalfBit-1: if rx_s==0 -> DATA, counter=0, bit index=0. Otherwise glitch -> IDLE with no pulse.
- DATA:
  - At counter==Divisor-1: shift rx_s into bit[index] (LSB first), counter=0.
  - After index 7 -> STOP, else index+1.
- STOP:
  - At counter==Divisor-1, sample rx_s.
  - rx_s==1 -> commit the byte, then go to IDLE.
  - rx_s==0 -> frame_err_o=1 for one cycle, byte discarded -> BREAK.
- BREAK:
  - Stay until rx_s==1, then -> IDLE. Prevents a held-low line from retriggering.
- Commit, evaluated in the stop-sample cycle; effects register on the next edge:
  - If valid_o==0, or valid_o&&ready_i in that same cycle: data_o <= byte, valid_o <= 1.
  - Otherwise: overrun_o=1 for one cycle, byte dropped, data_o and valid_o unchanged.
- Handshake:
  - Transfer occurs when valid_o&&ready_i.
  - Without a simultaneous commit, valid_o clears on the next edge.
  - data_o is stable while valid_o=1 and not accepted.
  - ready_i may be high with valid_o low; this has no effect.
- Latency: valid_o rises one clk_i after the stop-bit sample edge.
- Timing: stop-bit sample occurs HalfBit + 9*Divisor cycles after rx_s first reads low.
- frame_err_o and overrun_o are never high together, and are never high more than one cycle per frame.

Test Plan:
Bench uses ClockFrequency=160, DesiredBaudRate=10 -> Divisor=16, HalfBit=8. ready_i=1 unless noted.

1. Send 0xA5 as an 8N1 frame.
   - Expect valid_o=1 with data_o=0xA5 exactly 8+9*16+1 cycles after rx_s falls.
   - Expect valid_o to drop the next cycle.
   - Expect no error pulses.
2. Drive rx_i low for 4 cycles, then high.
   - Expect busy_o pulse.
   - Expect no valid_o, no frame_err_o.
   - Expect a return to IDLE at HalfBit.
3. Send 0x3C with the stop bit low, holding the line low 40 more cycles, then send 0x5A.
   - Expect a single frame_err_o pulse and no valid_o for 0x3C.
   - Expect busy_o to stay high until the line goes high.
   - Expect 0x5A to be then received correctly.
4. With ready_i=0, send 0x11 then 0x22 back-to-back.
   - Expect valid_o=1 and data_o=0x11 throughout.
   - Expect a single overrun_o pulse at 0x22's stop sample.
   - Raise ready_i: expect 0x11 consumed, then valid_o=0.
5. With ready_i=0, hold 0x11; raise ready_i exactly in 0x22's stop-sample cycle.
   - Expect 0x11 accepted.
   - Expect data_o=0x22, valid_o=1 the next cycle.
   - Expect no overrun_o.
6. Assert rst_ni=0 during bit 4 of 0xFF, release, then send 0x81.
   - Expect all outputs 0 immediately, asynchronously.
   - Expect no pulses for the aborted frame.
   - Expect 0x81 received correctly.

Source files
------------

// File: rtl/uart_rx_deser.sv
// UART 8N1 receive deserializer: oversamples the synchronized RX line and emits bytes on a valid/ready stream.
// Latency: valid_o rises HalfBit + 9*Divisor + 1 cycles after the synchronized line first reads low.
// Backpressure: one holding register; a byte arriving while it is still full and not being accepted is dropped with an overrun_o pulse.
module uart_rx_deser #(
  parameter int DesiredBaudRate = 9_600,
  parameter int ClockFrequency  = 12_000_000
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       rx_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  input  logic       ready_i,
  output logic       frame_err_o,
  output logic       overrun_o,
  output logic       busy_o
);

  localparam int Divisor = ClockFrequency / DesiredBaudRate;
  localparam int HalfBit = Divisor / 2;
  localparam int CntW    = $clog2(Divisor);

  // Need at least a few clocks per bit for the mid-bit sampling scheme to make sense.
  if (Divisor < 4) begin : g_divisor_check
    $error("uart_rx_deser: ClockFrequency/DesiredBaudRate must be at least 4");
  end

  localparam logic [CntW-1:0] HalfLast = CntW'(HalfBit - 1);
  localparam logic [CntW-1:0] BitLast  = CntW'(Divisor - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } state_t;

  logic            rx_meta;
  logic            rx_s;
  state_t          state;
  logic [CntW-1:0] cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      shift;
  logic [7:0]      data_q;
  logic            valid_q;
  logic            frame_err_q;
  logic            overrun_q;
  logic            busy_q;

  // Two-flop synchronizer; resets to the idle (high) line level so reset never looks like a start bit.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx_i;
      rx_s    <= rx_meta;
    end
  end

  // Receive FSM with the output holding register; all outputs are registered here.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= IDLE;
      cnt         <= '0;
      bit_idx     <= 3'd0;
      shift       <= 8'h00;
      data_q      <= 8'h00;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      // Consumer takes the byte; a commit in the same cycle below overrides this.
      if (valid_q && ready_i) begin
        valid_q <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state  <= START;
            cnt    <= '0;
            busy_q <= 1'b1;
          end
        end
        START: begin
          if (cnt == HalfLast) begin
            cnt <= '0;
            if (!rx_s) begin
              state   <= DATA;
              bit_idx <= 3'd0;
            end else begin
              // Line went back high before mid start bit: treat as a glitch.
              state  <= IDLE;
              busy_q <= 1'b0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == BitLast) begin
            cnt            <= '0;
            shift[bit_idx] <= rx_s;
            if (bit_idx == 3'd7) begin
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (cnt == BitLast) begin
            cnt <= '0;
            if (rx_s) begin
              state  <= IDLE;
              busy_q <= 1'b0;
              if (!valid_q || ready_i) begin
                data_q  <= shift;
                valid_q <= 1'b1;
              end else begin
                overrun_q <= 1'b1;
              end
            end else begin
              frame_err_q <= 1'b1;
              state       <= BREAK;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        BREAK: begin
          // Wait for the line to return high so a held-low line cannot retrigger.
          if (rx_s) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign data_o      = data_q;
  assign valid_o     = valid_q;
  assign frame_err_o = frame_err_q;
  assign overrun_o   = overrun_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_uart_rx_deser.sv
// Directed bench for uart_rx_deser at Divisor=16, HalfBit=8.
// Frames are driven on rx_i; a negedge monitor records stream events with cycle stamps.
// Table-driven frames plus hand-written sequences for glitch, break, overrun, handshake and reset.
module tb_uart_rx_deser;

  logic       clk_i   = 1'b0;
  logic       rst_ni  = 1'b1;
  logic       rx_i    = 1'b1;
  logic       ready_i = 1'b1;
  logic [7:0] data_o;
  logic       valid_o;
  logic       frame_err_o;
  logic       overrun_o;
  logic       busy_o;

  uart_rx_deser #(
    .DesiredBaudRate(10),
    .ClockFrequency (160)
  ) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .rx_i       (rx_i),
    .data_o     (data_o),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .frame_err_o(frame_err_o),
    .overrun_o  (overrun_o),
    .busy_o     (busy_o)
  );

  always #5 clk_i = ~clk_i;

  // Expected stop-sample to visible-valid offset from the edge that launched the start bit:
  // 2 synchronizer edges + HalfBit + 9*Divisor + 1 = 2 + 8 + 144 + 1 = 155.
  localparam int Lat = 155;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Monitor state
  int         rise_cnt = 0;
  int         last_rise_cyc = 0;
  logic [7:0] last_rise_dat = 8'h00;
  int         acc_cnt = 0;
  logic [7:0] last_acc = 8'h00;
  int         fe_cnt = 0;
  int         ov_cnt = 0;
  int         last_ov_cyc = 0;
  int         both_cnt = 0;
  int         unstable_cnt = 0;
  logic       prev_vld = 1'b0;
  logic       prev_rdy = 1'b0;
  logic [7:0] prev_dat = 8'h00;
  int         frame_start = 0;

  always @(negedge clk_i) begin
    if (rst_ni) begin
      if (valid_o && !prev_vld) begin
        rise_cnt      = rise_cnt + 1;
        last_rise_cyc = cyc;
        last_rise_dat = data_o;
      end
      if (valid_o && ready_i) begin
        acc_cnt  = acc_cnt + 1;
        last_acc = data_o;
      end
      if (frame_err_o) fe_cnt = fe_cnt + 1;
      if (overrun_o) begin
        ov_cnt      = ov_cnt + 1;
        last_ov_cyc = cyc;
      end
      if (frame_err_o && overrun_o) both_cnt = both_cnt + 1;
      if (prev_vld && !prev_rdy && (!valid_o || data_o != prev_dat)) unstable_cnt = unstable_cnt + 1;
    end
    prev_vld = valid_o;
    prev_rdy = ready_i;
    prev_dat = data_o;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Start bit launched just after an edge; each bit lasts 16 clocks; extra_low stretches a low stop bit.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int extra_low);
    @(posedge clk_i);
    #1;
    frame_start = cyc;
    rx_i = 1'b0;
    repeat (16) @(posedge clk_i);
    #1;
    for (int i = 0; i < 8; i++) begin
      rx_i = b[i];
      repeat (16) @(posedge clk_i);
      #1;
    end
    rx_i = stop;
    repeat (16 + (stop ? 0 : extra_low)) @(posedge clk_i);
    #1;
    rx_i = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  typedef struct {
    logic [7:0] tx;
    logic       stop;
    logic       exp_vld;
    logic [7:0] exp_dat;
    int         exp_fe;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int r0, f0, o0, a0, bad;

    vecs[0] = '{tx: 8'hA5, stop: 1'b1, exp_vld: 1'b1, exp_dat: 8'hA5, exp_fe: 0};
    vecs[1] = '{tx: 8'h00, stop: 1'b1, exp_vld: 1'b1, exp_dat: 8'h00, exp_fe: 0};
    vecs[2] = '{tx: 8'hFF, stop: 1'b1, exp_vld: 1'b1, exp_dat: 8'hFF, exp_fe: 0};
    vecs[3] = '{tx: 8'h01, stop: 1'b1, exp_vld: 1'b1, exp_dat: 8'h01, exp_fe: 0};
    vecs[4] = '{tx: 8'h80, stop: 1'b1, exp_vld: 1'b1, exp_dat: 8'h80, exp_fe: 0};
    vecs[5] = '{tx: 8'h3C, stop: 1'b0, exp_vld: 1'b0, exp_dat: 8'h00, exp_fe: 1};
    vecs[6] = '{tx: 8'hC3, stop: 1'b1, exp_vld: 1'b1, exp_dat: 8'hC3, exp_fe: 0};

    // Reset state
    #2 rst_ni = 1'b0;
    #20;
    chk("rst_data", data_o, 8'h00);
    chk("rst_valid", valid_o, 1'b0);
    chk("rst_fe", frame_err_o, 1'b0);
    chk("rst_ov", overrun_o, 1'b0);
    chk("rst_busy", busy_o, 1'b0);
    @(posedge clk_i);
    #1 rst_ni = 1'b1;
    idle(5);

    // 1: 0xA5 with exact latency and one-cycle valid
    f0 = fe_cnt; o0 = ov_cnt;
    fork
      send_frame(8'hA5, 1'b1, 0);
      begin
        @(posedge clk_i);
        repeat (Lat) @(negedge clk_i);
        chk("t1_valid_early", valid_o, 1'b0);
        @(negedge clk_i);
        chk("t1_valid", valid_o, 1'b1);
        chk("t1_data", data_o, 8'hA5);
        @(negedge clk_i);
        chk("t1_valid_drop", valid_o, 1'b0);
      end
    join
    idle(10);
    chk("t1_no_fe", fe_cnt - f0, 0);
    chk("t1_no_ov", ov_cnt - o0, 0);

    // Table of single frames with ready_i high
    for (int i = 0; i < 7; i++) begin
      r0 = rise_cnt; f0 = fe_cnt; o0 = ov_cnt;
      send_frame(vecs[i].tx, vecs[i].stop, 0);
      idle(20);
      chk("vec_valid_cnt", rise_cnt - r0, {31'd0, vecs[i].exp_vld});
      if (vecs[i].exp_vld) begin
        chk("vec_data", last_rise_dat, vecs[i].exp_dat);
        chk("vec_latency", last_rise_cyc - frame_start, Lat);
      end
      chk("vec_fe", fe_cnt - f0, vecs[i].exp_fe);
      chk("vec_ov", ov_cnt - o0, 0);
    end

    // 2: short low glitch; START lasts HalfBit cycles then returns to IDLE
    r0 = rise_cnt; f0 = fe_cnt;
    fork
      begin
        @(posedge clk_i);
        #1 rx_i = 1'b0;
        repeat (4) @(posedge clk_i);
        #1 rx_i = 1'b1;
      end
      begin
        @(posedge clk_i);
        for (int n = 1; n <= 14; n++) begin
          @(negedge clk_i);
          chk("t2_busy", busy_o, (n >= 4 && n <= 11));
        end
      end
    join
    idle(30);
    chk("t2_no_valid", rise_cnt - r0, 0);
    chk("t2_no_fe", fe_cnt - f0, 0);

    // 3: framing error, held-low line, then recovery with 0x5A
    r0 = rise_cnt; f0 = fe_cnt;
    fork
      send_frame(8'h3C, 1'b0, 40);
      begin
        @(posedge clk_i);
        repeat (Lat) @(negedge clk_i);
        chk("t3_fe_early", frame_err_o, 1'b0);
        @(negedge clk_i);
        chk("t3_fe", frame_err_o, 1'b1);
        @(negedge clk_i);
        chk("t3_fe_drop", frame_err_o, 1'b0);
        repeat (203 - 157) @(negedge clk_i);
        chk("t3_busy_break", busy_o, 1'b1);
        @(negedge clk_i);
        chk("t3_busy_idle", busy_o, 1'b0);
      end
    join
    chk("t3_fe_cnt", fe_cnt - f0, 1);
    chk("t3_no_valid", rise_cnt - r0, 0);
    idle(10);
    send_frame(8'h5A, 1'b1, 0);
    idle(20);
    chk("t3_recover_cnt", rise_cnt - r0, 1);
    chk("t3_recover_data", last_rise_dat, 8'h5A);

    // 4: overrun with ready_i low
    #0 ready_i = 1'b0;
    o0 = ov_cnt; a0 = acc_cnt;
    send_frame(8'h11, 1'b1, 0);
    chk("t4_hold_valid", valid_o, 1'b1);
    chk("t4_hold_data", data_o, 8'h11);
    bad = 0;
    fork
      send_frame(8'h22, 1'b1, 0);
      begin
        repeat (170) begin
          @(negedge clk_i);
          if (!(valid_o && data_o == 8'h11)) bad = bad + 1;
        end
      end
    join
    chk("t4_held_throughout", bad, 0);
    chk("t4_ov_cnt", ov_cnt - o0, 1);
    chk("t4_ov_cycle", last_ov_cyc - frame_start, Lat);
    @(posedge clk_i);
    #1 ready_i = 1'b1;
    repeat (3) @(negedge clk_i);
    chk("t4_drained", valid_o, 1'b0);
    chk("t4_acc_cnt", acc_cnt - a0, 1);
    chk("t4_acc_data", last_acc, 8'h11);

    // 5: ready_i rises exactly in the stop-sample cycle of the second byte
    idle(5);
    ready_i = 1'b0;
    o0 = ov_cnt; a0 = acc_cnt;
    send_frame(8'h11, 1'b1, 0);
    fork
      send_frame(8'h22, 1'b1, 0);
      begin
        @(posedge clk_i);
        repeat (Lat - 1) @(posedge clk_i);
        #1 ready_i = 1'b1;
        @(posedge clk_i);
        #1 ready_i = 1'b0;
        @(negedge clk_i);
        chk("t5_valid", valid_o, 1'b1);
        chk("t5_data", data_o, 8'h22);
        chk("t5_no_ov_pulse", overrun_o, 1'b0);
      end
    join
    chk("t5_ov_cnt", ov_cnt - o0, 0);
    chk("t5_acc_cnt", acc_cnt - a0, 1);
    chk("t5_acc_data", last_acc, 8'h11);
    @(posedge clk_i);
    #1 ready_i = 1'b1;
    repeat (3) @(negedge clk_i);
    chk("t5_acc_second", last_acc, 8'h22);
    chk("t5_drained", valid_o, 1'b0);

    // 6: asynchronous reset during bit 4 of 0xFF, then 0x81
    r0 = rise_cnt; f0 = fe_cnt; o0 = ov_cnt;
    fork
      send_frame(8'hFF, 1'b1, 0);
      begin
        @(posedge clk_i);
        repeat (88) @(posedge clk_i);
        #1;
        chk("t6_busy_before", busy_o, 1'b1);
        #2 rst_ni = 1'b0;
        #1;
        chk("t6_rst_data", data_o, 8'h00);
        chk("t6_rst_valid", valid_o, 1'b0);
        chk("t6_rst_busy", busy_o, 1'b0);
        chk("t6_rst_fe", frame_err_o, 1'b0);
        chk("t6_rst_ov", overrun_o, 1'b0);
        repeat (3) @(posedge clk_i);
        #1 rst_ni = 1'b1;
      end
    join
    idle(10);
    chk("t6_no_valid", rise_cnt - r0, 0);
    chk("t6_no_fe", fe_cnt - f0, 0);
    chk("t6_no_ov", ov_cnt - o0, 0);
    chk("t6_idle_busy", busy_o, 1'b0);
    send_frame(8'h81, 1'b1, 0);
    idle(20);
    chk("t6_after_cnt", rise_cnt - r0, 1);
    chk("t6_after_data", last_rise_dat, 8'h81);
    chk("t6_after_latency", last_rise_cyc - frame_start, Lat);

    // Global stream properties across the whole run
    chk("never_both_pulses", both_cnt, 0);
    chk("data_stable_while_held", unstable_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
